// File: rtl/dmem_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_run_ctrl_if
// Brief  : Host-side data-memory access bus for the run controller.
// Rev    : 1.0  initial release
// ============================================================================
interface dmem_run_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    modport master (
        output host_req,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_gnt,
        input  host_rdata,
        input  host_rvalid
    );

    modport slave (
        input  host_req,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_gnt,
        output host_rdata,
        output host_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/dmem_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_run_ctrl
// Brief  : Run sequencer (IDLE/ARM/RUN/DONE), data-memory port arbiter and
//          cycle-limit timeout for the single-cycle 9-bit core.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_run_ctrl #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          start_i,
    dmem_run_ctrl_if.slave     host,
    input  wire logic          core_we_i,
    input  wire logic [AW-1:0] core_addr_i,
    input  wire logic [DW-1:0] core_wdata_i,
    input  wire logic          core_done_i,
    output logic               mem_we_o,
    output logic      [AW-1:0] mem_addr_o,
    output logic      [DW-1:0] mem_wdata_o,
    input  wire logic [DW-1:0] mem_rdata_i,
    output logic               core_rst_o,
    output logic               core_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic      [CW-1:0] cycle_count_o
);

    localparam logic [CW-1:0] C_LIMIT = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic          timeout_q, timeout_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    logic          w_host_own;
    logic          w_host_gnt;
    logic          w_arm_entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Next state and per-state core controls.
    always_comb begin
        state_d    = state_q;
        core_rst_o = 1'b1;
        core_en_o  = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_ARM;
            end
            S_ARM: begin
                busy_o  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                core_rst_o = 1'b0;
                core_en_o  = 1'b1;
                busy_o     = 1'b1;
                if (core_done_i || (cycle_q == C_LIMIT)) state_d = S_DONE;
            end
            S_DONE: begin
                core_rst_o = 1'b0;
                done_o     = 1'b1;
                if (start_i) state_d = S_ARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_arm_entry = (state_q != S_ARM) && (state_d == S_ARM);

    // The final RUN cycle still counts; a halt on that same cycle wins over the limit.
    always_comb begin
        cycle_d   = cycle_q;
        timeout_d = timeout_q;
        if (w_arm_entry) begin
            cycle_d   = '0;
            timeout_d = 1'b0;
        end else if (state_q == S_RUN) begin
            cycle_d = cycle_q + CW'(1);
            if (!core_done_i && (cycle_q == C_LIMIT)) timeout_d = 1'b1;
        end
    end

    assign w_host_own = (state_q != S_RUN);
    assign w_host_gnt = host.host_req & w_host_own;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = host.host_addr;
        mem_wdata_o = host.host_wdata;
        if (w_host_own) begin
            mem_we_o    = w_host_gnt & host.host_we;
            mem_addr_o  = host.host_addr;
            mem_wdata_o = host.host_wdata;
        end else begin
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end
    end

    always_comb begin
        rvalid_d = w_host_gnt & ~host.host_we;
        rdata_d  = rvalid_d ? mem_rdata_i : rdata_q;
    end

    assign host.host_gnt    = w_host_gnt;
    assign host.host_rdata  = rdata_q;
    assign host.host_rvalid = rvalid_q;

    assign timeout_o     = timeout_q;
    assign cycle_count_o = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_run_ctrl
// Brief  : Directed self-checking bench for dmem_run_ctrl with a small dat_mem.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_run_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int MAXC = 20;

    logic          clk;
    logic          reset;
    logic          start;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          core_rst;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    dmem_run_ctrl_if #(.AW(AW), .DW(DW)) hif ();

    dmem_run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYCLES(MAXC)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .host          (hif.slave),
        .core_we_i     (core_we),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_done_i   (core_done),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .core_rst_o    (core_rst),
        .core_en_o     (core_en),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_o     (timeout),
        .cycle_count_o (cycle_count)
    );

    logic [DW-1:0] mem [256];
    always_ff @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        core_we = 1'b0; core_addr = '0; core_wdata = '0; core_done = 1'b0;
        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycle", 32'(cycle_count), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_rvalid", 32'(hif.host_rvalid), 32'd0);
        chk("rst_rdata", 32'(hif.host_rdata), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("idle_core_rst", 32'(core_rst), 32'd1);
        hif.host_req = 1'b1; #1;
        chk("idle_gnt_req1", 32'(hif.host_gnt), 32'd1);
        hif.host_req = 1'b0; #1;
        chk("idle_gnt_req0", 32'(hif.host_gnt), 32'd0);

        // Host write A5 @10, write 11 @30, read back @10
        hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 8'h10; hif.host_wdata = 8'hA5; #1;
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        tick();
        hif.host_addr = 8'h30; hif.host_wdata = 8'h11;
        tick();
        chk("wr_no_rvalid", 32'(hif.host_rvalid), 32'd0);
        hif.host_we = 1'b0; hif.host_addr = 8'h10; #1;
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        tick();
        hif.host_req = 1'b0;
        chk("rd_rvalid", 32'(hif.host_rvalid), 32'd1);
        chk("rd_rdata", 32'(hif.host_rdata), 32'hA5);
        tick();
        chk("rd_rvalid_pulse", 32'(hif.host_rvalid), 32'd0);

        // Run halting on 5th RUN cycle
        start = 1'b1; tick(); start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_core_rst", 32'(core_rst), 32'd1);
        chk("arm_core_en", 32'(core_en), 32'd0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            chk("run_core_en", 32'(core_en), 32'd1);
            chk("run_core_rst", 32'(core_rst), 32'd0);
            chk("run_cycle", 32'(cycle_count), 32'(i - 1));
            if (i == 5) core_done = 1'b1;
            tick();
        end
        core_done = 1'b0;
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_core_en", 32'(core_en), 32'd0);
        chk("halt_core_rst", 32'(core_rst), 32'd0);
        chk("halt_cycle", 32'(cycle_count), 32'd5);
        chk("halt_timeout", 32'(timeout), 32'd0);

        // Run to the cycle limit
        start = 1'b1; tick(); start = 1'b0;
        chk("arm2_cycle_clr", 32'(cycle_count), 32'd0);
        tick();
        for (int i = 1; i <= MAXC; i++) begin
            chk("lim_not_done", 32'(done), 32'd0);
            tick();
        end
        chk("lim_done", 32'(done), 32'd1);
        chk("lim_cycle", 32'(cycle_count), 32'(MAXC));
        chk("lim_timeout", 32'(timeout), 32'd1);
        tick();
        chk("lim_done_held", 32'(done), 32'd1);
        chk("lim_cycle_held", 32'(cycle_count), 32'(MAXC));

        // core_done coincides with the limit cycle
        start = 1'b1; tick(); start = 1'b0;
        chk("arm3_timeout_clr", 32'(timeout), 32'd0);
        tick();
        repeat (MAXC - 1) tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        chk("coin_done", 32'(done), 32'd1);
        chk("coin_timeout", 32'(timeout), 32'd0);
        chk("coin_cycle", 32'(cycle_count), 32'(MAXC));

        // Core store in RUN while host waits
        start = 1'b1; tick(); start = 1'b0;
        tick();
        core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h3C;
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 8'h20; #1;
        chk("run_host_gnt", 32'(hif.host_gnt), 32'd0);
        chk("run_mem_we", 32'(mem_we), 32'd1);
        chk("run_mem_addr", 32'(mem_addr), 32'h20);
        chk("run_mem_wdata", 32'(mem_wdata), 32'h3C);
        core_done = 1'b1; tick(); core_done = 1'b0;
        chk("one_cycle_run", 32'(cycle_count), 32'd1);
        chk("run_no_rvalid", 32'(hif.host_rvalid), 32'd0);
        chk("done_host_gnt", 32'(hif.host_gnt), 32'd1);
        chk("done_core_we_drop", 32'(mem_we), 32'd0);
        core_we = 1'b0;
        tick();
        chk("done_rvalid", 32'(hif.host_rvalid), 32'd1);
        chk("done_rdata", 32'(hif.host_rdata), 32'h3C);

        // start together with a granted read in DONE
        hif.host_addr = 8'h10; start = 1'b1; tick();
        start = 1'b0; hif.host_req = 1'b0;
        chk("start_rd_busy", 32'(busy), 32'd1);
        chk("start_rd_rvalid", 32'(hif.host_rvalid), 32'd1);
        chk("start_rd_rdata", 32'(hif.host_rdata), 32'hA5);

        // Reset asserted on 3rd RUN cycle with a core store in flight
        tick(); tick(); tick();
        core_we = 1'b1; core_addr = 8'h30; core_wdata = 8'h77; #1;
        chk("r3_core_en", 32'(core_en), 32'd1);
        chk("r3_cycle", 32'(cycle_count), 32'd2);
        #2 reset = 1'b0; #1;
        chk("arst_core_en", 32'(core_en), 32'd0);
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cycle", 32'(cycle_count), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        tick();
        reset = 1'b1; core_we = 1'b0;
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 8'h30;
        tick();
        hif.host_req = 1'b0;
        chk("arst_store_drop", 32'(hif.host_rdata), 32'h11);
        start = 1'b1; tick(); start = 1'b0;
        chk("rerun_arm_cycle", 32'(cycle_count), 32'd0);
        tick();
        chk("rerun_run1_cycle", 32'(cycle_count), 32'd0);
        tick();
        chk("rerun_run2_cycle", 32'(cycle_count), 32'd1);
        core_done = 1'b1; tick(); core_done = 1'b0;
        chk("rerun_done", 32'(done), 32'd1);
        chk("rerun_cycle", 32'(cycle_count), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_run_ctrl.md
Name: dmem_run_ctrl

Overview:
- Run controller for the single-cycle 9-bit core. It sequences a program run: hold, arm, run, done.
- Arbitrates the single data-memory port between the host/testbench loader and the core.
- Counts execution cycles and enforces a cycle-limit timeout.
- Sits between top-level core signals (PC enable, core reset, data-memory controls, done decode) and dat_mem.

Parameters:
AW, 8, data-memory address width
DW, 8, data width
CW, 16, cycle-counter width
MAX_CYCLES, 4096, RUN-cycle limit before forced stop; must be ≥1 and < 2^CW

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a run; level sampled each cycle
host_req  input  1  host memory access request
host_we  input  1  host write (1) / read (0)
host_addr  input  AW  host address
host_wdata  input  DW  host write data
host_gnt  output  1  host access accepted this cycle (combinational)
host_rdata  output  DW  registered read data
host_rvalid  output  1  one-cycle pulse, host_rdata valid
core_we  input  1  core store enable (MemWrite)
core_addr  input  AW  core address
core_wdata  input  DW  core store data
core_done  input  1  core halt decode (all-ones instruction)
mem_we  output  1  to dat_mem wr_en
mem_addr  output  AW  to dat_mem addr
mem_wdata  output  DW  to dat_mem dat_in
mem_rdata  input  DW  from dat_mem (combinational read)
core_rst  output  1  holds core PC/regs in reset, active-high
core_en  output  1  PC/regfile/flag advance enable
busy  output  1  state is ARM or RUN
done  output  1  state is DONE
timeout  output  1  last run ended at the cycle limit
cycle_count  output  CW  RUN cycles of current/last run

Behaviour:
- States: IDLE, ARM, RUN, DONE. Reset (async, reset=0) -> IDLE; cycle_count=0, timeout=0, host_rvalid=0, host_rdata=0.
- Outputs per state:
  - IDLE: core_rst=1, core_en=0.
  - ARM: core_rst=1, core_en=0.
  - RUN: core_rst=0, core_en=1.
  - DONE: core_rst=0, core_en=0; core state frozen for inspection.
- Transitions:
  - IDLE: start -> ARM.
  - ARM: always -> RUN after exactly 1 cycle. On entry, cycle_count and timeout clear.
  - RUN: core_done -> DONE. Otherwise, cycle_count==MAX_CYCLES-1 -> DONE with timeout<=1. core_done takes priority over timeout in the same cycle (timeout stays 0).
  - DONE: start -> ARM (re-run). DONE is otherwise held indefinitely.
- cycle_count increments by 1 on every RUN cycle, including the final one. A run halting on its first RUN cycle reports 1. No wrap: MAX_CYCLES bounds it.
- Arbitration:
  - Host owns the memory port in IDLE, ARM and DONE: host_gnt=host_req; mem_we=host_req&host_we; mem_addr=host_addr; mem_wdata=host_wdata.
  - Core owns the port in RUN: mem_we=core_we; mem_addr=core_addr; mem_wdata=core_wdata; host_gnt=0.
  - Core stores outside RUN are dropped (mem_we never driven by core).
  - Mux outputs are combinational; no added latency for the core.
- Host read: if host_gnt&~host_we, host_rdata<=mem_rdata and host_rvalid pulses the next cycle. Granted writes complete at the same edge. host_rvalid=0 otherwise.
- start together with a granted host access in IDLE/DONE: both are honoured. The access completes this cycle and the state moves to ARM. host_rvalid still pulses next cycle.
- host_req while in RUN: not granted. The host must hold the request; it is granted from the first DONE cycle onward.
- Reset asserted mid-RUN: immediate return to IDLE; core_rst=1 and core_en=0 asynchronously. Any in-flight core store at that edge is suppressed.
- start held high through DONE re-arms every run; this is intended single-step-free re-execution.

Test Plan:
1. reset=0 then 1; no start -> state IDLE, core_rst=1, core_en=0, busy=0, done=0, cycle_count=0, host_gnt follows host_req.
2. IDLE: host writes 8'hA5 to addr 8'h10, then reads addr 8'h10 -> mem_we=1 on write cycle; next read cycle host_rvalid=1, host_rdata=8'hA5.
3. start pulse; core_done asserted on 5th RUN cycle -> 1 ARM cycle (core_rst=1), 5 cycles core_en=1, then done=1, cycle_count=5, timeout=0.
4. MAX_CYCLES=20, core_done never asserted -> DONE after 20 RUN cycles, cycle_count=20, timeout=1; core_done and limit coinciding on cycle 20 -> timeout=0.
5. RUN with core_we=1, addr 8'h20, data 8'h3C while host_req=1 -> host_gnt=0, memory gets 8'h3C. Host request held -> granted on first DONE cycle; read returns 8'h3C.
6. reset driven 0 on 3rd RUN cycle -> core_en=0 and core_rst=1 immediately (same cycle, no clock edge), state IDLE, cycle_count=0. Re-run via start -> cycle_count restarts from 0.
